// File: rtl/core_seq_if.sv
// core_seq_if -- instruction and data memory bus for the core_seq sequencer.
//   master : the sequencer (drives requests, receives ready/data)
//   slave  : the memory side (drives ready/data, receives requests)
//   imem_req/imem_addr  fetch request and address
//   imem_ready/imem_rdata  fetch completion and instruction word
//   dmem_req/dmem_we    data request and write qualifier
//   dmem_ready/dmem_rdata  data completion and load data
interface core_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/core_seq.sv
// core_seq -- multi-cycle instruction sequencer (one instruction in flight).
// Walks FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, retiring on every
// return to FETCH, and parks in TRAP on timeout, illegal op or misaligned
// branch target until reset.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   bus (master)          imem/dmem handshake bus
//   ir, pc                latched instruction word, current instruction address
//   ex_*                  exec-stage controls, sampled only in EXEC
//   mem_rdata_q           latched load data
//   rf_we                 register-file write strobe (WB)
//   state                 FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//   halted, trap_cause    trap indication (1 timeout, 2 illegal, 3 misaligned)
//   instret               retired instruction count (wraps)
module core_seq #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  core_seq_if.master  bus,
  output logic [31:0] ir,
  output logic [31:0] pc,
  input  logic        ex_mem_r,
  input  logic        ex_mem_w,
  input  logic        ex_reg_w,
  input  logic        ex_branch,
  input  logic        ex_illegal,
  input  logic [31:0] ex_branch_pc,
  output logic [31:0] mem_rdata_q,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // Last wait cycle index before the timeout fires; the counter holds the
  // number of ready-less cycles already spent in the current FETCH/MEM visit.
  localparam logic [7:0] WLIM = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        run_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] mrd_q, mrd_d;
  logic [31:0] icnt_q, icnt_d;
  logic        mem_w_q, mem_w_d;
  logic        reg_w_q, reg_w_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [1:0]  cause_q, cause_d;
  logic        retire;

  // run rises on the first edge after reset release, so the fetch request
  // never appears in the same cycle reset is deasserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      npc_q   <= '0;
      mrd_q   <= '0;
      icnt_q  <= '0;
      mem_w_q <= 1'b0;
      reg_w_q <= 1'b0;
      wcnt_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      mrd_q   <= mrd_d;
      icnt_q  <= icnt_d;
      mem_w_q <= mem_w_d;
      reg_w_q <= reg_w_d;
      wcnt_q  <= wcnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    npc_d   = npc_q;
    mrd_d   = mrd_q;
    icnt_d  = icnt_q;
    mem_w_d = mem_w_q;
    reg_w_d = reg_w_q;
    wcnt_d  = wcnt_q;
    cause_d = cause_q;
    retire  = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (run_q) begin
          // ready is checked first so a response on the limit cycle wins
          if (bus.imem_ready) begin
            ir_d    = bus.imem_rdata;
            state_d = S_DECODE;
          end else if (wcnt_q == WLIM) begin
            state_d = S_TRAP;
            cause_d = 2'd1;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
      end

      S_DECODE: state_d = S_EXEC;

      S_EXEC: begin
        npc_d   = ex_branch ? ex_branch_pc : pc_q + 32'd4;
        mem_w_d = ex_mem_w;
        reg_w_d = ex_reg_w;
        if (ex_illegal || (ex_mem_r && ex_mem_w)) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else if (ex_branch && (ex_branch_pc[1:0] != 2'b00)) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end else if (ex_mem_r || ex_mem_w) begin
          state_d = S_MEM;
        end else if (ex_reg_w) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end

      S_MEM: begin
        if (bus.dmem_ready) begin
          if (!mem_w_q) mrd_d = bus.dmem_rdata;
          if (reg_w_q) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (wcnt_q == WLIM) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end

      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end

      S_TRAP: ;

      default: state_d = S_TRAP;
    endcase

    // npc_d already holds the freshly computed target when retiring from EXEC
    if (retire) begin
      pc_d   = npc_d;
      icnt_d = icnt_q + 32'd1;
    end

    // every state entry starts a fresh wait budget
    if (state_d != state_q) wcnt_d = '0;
  end

  // Strobes decode straight from the state register so reset clears them
  // asynchronously and they are mutually exclusive by construction.
  assign bus.imem_req  = run_q && (state_q == S_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.dmem_req  = (state_q == S_MEM);
  assign bus.dmem_we   = (state_q == S_MEM) && mem_w_q;
  assign rf_we         = (state_q == S_WB);
  assign halted        = (state_q == S_TRAP);

  assign ir          = ir_q;
  assign pc          = pc_q;
  assign mem_rdata_q = mrd_q;
  assign state       = state_q;
  assign trap_cause  = cause_q;
  assign instret     = icnt_q;

endmodule

// File: tb/tb_core_seq.sv
module tb_core_seq;
  localparam int          TMO = 6;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_seq_if bus();
  logic [31:0] ir, pc, mem_rdata_q, instret, ex_branch_pc;
  logic        ex_mem_r, ex_mem_w, ex_reg_w, ex_branch, ex_illegal;
  logic        rf_we, halted;
  logic [2:0]  state;
  logic [1:0]  trap_cause;

  core_seq #(.RESET_PC(RPC), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ir(ir), .pc(pc),
    .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w), .ex_reg_w(ex_reg_w),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal), .ex_branch_pc(ex_branch_pc),
    .mem_rdata_q(mem_rdata_q), .rf_we(rf_we), .state(state),
    .halted(halted), .trap_cause(trap_cause), .instret(instret)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Expected observable outputs for one clock cycle.
  typedef struct {
    logic [2:0]  st;
    logic        ireq, dreq, dwe, rfw;
    logic [1:0]  cause;
    logic [31:0] pc, ir, icnt, mrd;
  } exp_t;
  exp_t q[$];

  // Architectural model state.
  logic [31:0] m_pc, m_ir, m_icnt, m_mrd;
  logic [1:0]  m_cause;

  typedef struct {
    int fw;  logic [31:0] word;
    logic mr, mw, rw, br, ill;
    logic [31:0] bpc;
    int mwait; logic [31:0] ld;
    int rst_mid;  // 0 none, 1 reset during MEM, 2 reset during WB
  } plan_t;

  task automatic push(input logic [2:0] st, input logic ireq, dreq, dwe, rfw);
    exp_t e;
    e.st = st; e.ireq = ireq; e.dreq = dreq; e.dwe = dwe; e.rfw = rfw;
    e.cause = m_cause; e.pc = m_pc; e.ir = m_ir; e.icnt = m_icnt; e.mrd = m_mrd;
    q.push_back(e);
  endtask

  task automatic rnd_in();
    bus.imem_ready = 1'($urandom); bus.imem_rdata = $urandom;
    bus.dmem_ready = 1'($urandom); bus.dmem_rdata = $urandom;
    ex_mem_r = 1'($urandom); ex_mem_w = 1'($urandom); ex_reg_w = 1'($urandom);
    ex_branch = 1'($urandom); ex_illegal = 1'($urandom); ex_branch_pc = $urandom;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Entered at posedge+1; checks the asynchronous clear, then releases reset
  // and covers the single cycle where run is still low.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_ireq", 32'(bus.imem_req), 0);
    chk("rst_dreq", 32'(bus.dmem_req), 0);
    chk("rst_dwe", 32'(bus.dmem_we), 0);
    chk("rst_rfwe", 32'(rf_we), 0);
    chk("rst_pc", pc, RPC);
    chk("rst_ir", ir, 0);
    chk("rst_instret", instret, 0);
    chk("rst_mrd", mem_rdata_q, 0);
    chk("rst_cause", 32'(trap_cause), 0);
    chk("rst_halted", 32'(halted), 0);
    m_pc = RPC; m_ir = '0; m_icnt = '0; m_mrd = '0; m_cause = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rnd_in();
    push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rnd_in();
      push(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  // One instruction through the model, driving stimulus cycle by cycle.
  task automatic run(input plan_t p);
    logic [31:0] npc;
    for (int i = 0; i < p.fw && i < TMO; i++) begin
      rnd_in(); bus.imem_ready = 1'b0;
      push(3'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    end
    if (p.fw >= TMO) begin m_cause = 2'd1; return; end
    rnd_in(); bus.imem_ready = 1'b1; bus.imem_rdata = p.word;
    push(3'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    m_ir = p.word;
    rnd_in(); push(3'd1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    rnd_in();
    ex_mem_r = p.mr; ex_mem_w = p.mw; ex_reg_w = p.rw;
    ex_branch = p.br; ex_illegal = p.ill; ex_branch_pc = p.bpc;
    push(3'd2, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    if (p.ill || (p.mr && p.mw)) begin m_cause = 2'd2; return; end
    if (p.br && (p.bpc & 32'h3) != 0) begin m_cause = 2'd3; return; end
    npc = p.br ? p.bpc : m_pc + 32'd4;
    if (p.mr || p.mw) begin
      if (p.rst_mid == 1) begin
        rnd_in();
        chk("mid_mem_state", 32'(state), 3);
        chk("mid_mem_dreq", 32'(bus.dmem_req), 1);
        do_reset();
        return;
      end
      for (int i = 0; i < p.mwait && i < TMO; i++) begin
        rnd_in(); bus.dmem_ready = 1'b0;
        push(3'd3, 1'b0, 1'b1, p.mw, 1'b0); tick();
      end
      if (p.mwait >= TMO) begin m_cause = 2'd1; return; end
      rnd_in(); bus.dmem_ready = 1'b1; bus.dmem_rdata = p.ld;
      push(3'd3, 1'b0, 1'b1, p.mw, 1'b0); tick();
      if (!p.mw) m_mrd = p.ld;
    end
    if (p.rw) begin
      if (p.rst_mid == 2) begin
        rnd_in();
        chk("mid_wb_rfwe", 32'(rf_we), 1);
        do_reset();
        return;
      end
      rnd_in(); push(3'd4, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    end
    m_pc = npc;
    m_icnt = m_icnt + 32'd1;
  endtask

  function automatic plan_t mk(input int fw, input logic mr, mw, rw, br, ill,
                               input logic [31:0] bpc, input int mwait);
    plan_t p;
    p.fw = fw; p.word = $urandom; p.mr = mr; p.mw = mw; p.rw = rw;
    p.br = br; p.ill = ill; p.bpc = bpc; p.mwait = mwait; p.ld = $urandom;
    p.rst_mid = 0;
    return p;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("imem_req", 32'(bus.imem_req), 32'(e.ireq));
      chk("imem_addr", bus.imem_addr, e.pc);
      chk("dmem_req", 32'(bus.dmem_req), 32'(e.dreq));
      chk("dmem_we", 32'(bus.dmem_we), 32'(e.dwe));
      chk("rf_we", 32'(rf_we), 32'(e.rfw));
      chk("halted", 32'(halted), 32'(e.st == 3'd5));
      chk("trap_cause", 32'(trap_cause), 32'(e.cause));
      chk("pc", pc, e.pc);
      chk("ir", ir, e.ir);
      chk("instret", instret, e.icnt);
      chk("mem_rdata_q", mem_rdata_q, e.mrd);
      chk("strobe_excl", 32'(32'(bus.imem_req) + 32'(bus.dmem_req) + 32'(rf_we) <= 1), 1);
    end
  end

  initial begin
    plan_t p;
    logic [31:0] r, bpc;
    rnd_in();
    tick();
    do_reset();

    // ALU op, fetch ready after two wait cycles, writeback
    run(mk(2, 0, 0, 1, 0, 0, 0, 0));
    chk("alu_pc", pc, 32'h4);
    chk("alu_instret", instret, 32'd1);

    // load with one dmem wait cycle
    p = mk(0, 1, 0, 1, 0, 0, 0, 1); p.ld = 32'hDEADBEEF;
    run(p);
    chk("load_mrd", mem_rdata_q, 32'hDEADBEEF);
    chk("load_instret", instret, 32'd2);

    // branches: to 0x100, then 0x80, back to 0x100, then misaligned 0x82
    run(mk(0, 0, 0, 0, 1, 0, 32'h100, 0));
    chk("br_pc_100", pc, 32'h100);
    run(mk(1, 0, 0, 0, 1, 0, 32'h80, 0));
    chk("br_addr_80", bus.imem_addr, 32'h80);
    run(mk(0, 0, 0, 0, 1, 0, 32'h100, 0));
    run(mk(0, 0, 0, 0, 1, 0, 32'h82, 0));
    trap_cycles(3);
    chk("mis_cause", 32'(trap_cause), 3);
    chk("mis_pc", pc, 32'h100);
    chk("mis_halted", 32'(halted), 1);
    do_reset();

    // ready on the limit cycle wins, then fetch timeout
    run(mk(TMO - 1, 0, 0, 0, 0, 0, 0, 0));
    chk("lim_instret", instret, 32'd1);
    run(mk(1000, 0, 0, 0, 0, 0, 0, 0));
    trap_cycles(5);
    chk("tmo_cause", 32'(trap_cause), 1);
    chk("tmo_halted", 32'(halted), 1);
    do_reset();

    // store with dmem timeout
    run(mk(0, 0, 1, 0, 0, 0, 0, TMO));
    trap_cycles(2);
    chk("dtmo_cause", 32'(trap_cause), 1);
    do_reset();

    // read+write conflict is illegal
    run(mk(0, 1, 1, 1, 0, 0, 0, 0));
    trap_cycles(2);
    chk("ill_cause", 32'(trap_cause), 2);
    do_reset();

    // reset mid-MEM and mid-WB
    p = mk(0, 1, 0, 1, 0, 0, 0, 2); p.rst_mid = 1;
    run(p);
    chk("abort_mem_instret", instret, 0);
    p = mk(0, 0, 0, 1, 0, 0, 0, 0); p.rst_mid = 2;
    run(p);
    chk("abort_wb_instret", instret, 0);

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      bpc = $urandom & 32'hFFFF_FFFC;
      if (r[2:0] == 3'd0) bpc = bpc | 32'(r[4:3]);
      p = mk((r[9:8] == 2'd3) ? int'($urandom_range(TMO - 1, TMO)) : int'(r[6:5]),
             r[10], r[11] & r[12] & r[13], r[14], r[15] & r[16],
             (r[20:17] == 4'd0), bpc,
             (r[22:21] == 2'd3) ? int'($urandom_range(TMO - 1, TMO)) : int'(r[24:23]));
      if (r[30:25] == 6'd0) p.rst_mid = (r[31] ? 1 : 2);
      run(p);
      if (m_cause != 2'd0) begin
        trap_cycles(int'($urandom_range(1, 4)));
        do_reset();
      end
    end

    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
